smi_wbbus: RTL and testbench

//  Command decoder between the SMI byte port and the internal Wishbone bus.

---
 rtl/smi_wbbus_if.sv | 39 +++
 rtl/smi_wbbus.sv | 157 +++++++++++++++
 tb/tb_smi_wbbus.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smi_wbbus_if.sv
// smi_wbbus_if: bundles the three channels around the SMI command decoder.
//   SMI receive stream : S_RX_VALID/S_RX_READY/S_RX_DATA  (command bytes in)
//   SMI transmit stream: M_TX_VALID/M_TX_READY/M_TX_DATA  (response bytes out)
//   Wishbone master    : o_wb_* driven by the decoder, i_wb_* from the slave
// modport master = decoder side, modport slave = environment side.
interface smi_wbbus_if #(
  parameter int AW = 30
);
  logic          S_RX_VALID;
  logic          S_RX_READY;
  logic [7:0]    S_RX_DATA;
  logic          M_TX_VALID;
  logic          M_TX_READY;
  logic [7:0]    M_TX_DATA;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_stall;
  logic          i_wb_ack;
  logic [31:0]   i_wb_data;
  logic          i_wb_err;

  modport master (
    input  S_RX_VALID, S_RX_DATA, M_TX_READY,
           i_wb_stall, i_wb_ack, i_wb_data, i_wb_err,
    output S_RX_READY, M_TX_VALID, M_TX_DATA,
           o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
  );

  modport slave (
    output S_RX_VALID, S_RX_DATA, M_TX_READY,
           i_wb_stall, i_wb_ack, i_wb_data, i_wb_err,
    input  S_RX_READY, M_TX_VALID, M_TX_DATA,
           o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
  );
endinterface

// File: rtl/smi_wbbus.sv
// smi_wbbus: byte-stream command decoder driving single 32-bit Wishbone
// transactions, one at a time.
//   'R'(52) + 4 addr bytes          -> read,  reply 06 + 4 data bytes | 15
//   'W'(57) + 4 addr + 4 data bytes -> write, reply 06 | 15
//   anything else in IDLE           -> reply 3F
// Multi-byte fields are MSB first; o_wb_addr = byte_addr[AW+1:2].
// Ports:
//   i_clk   - system clock
//   i_reset - asynchronous active-high reset
//   bus     - smi_wbbus_if.master (RX stream, TX stream, Wishbone master)
module smi_wbbus #(
  parameter int AW        = 30,
  parameter int LGTIMEOUT = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  smi_wbbus_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_BUS  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [7:0] C_RD  = 8'h52;
  localparam logic [7:0] C_WR  = 8'h57;
  localparam logic [7:0] R_ACK = 8'h06;
  localparam logic [7:0] R_NAK = 8'h15;
  localparam logic [7:0] R_UNK = 8'h3F;

  logic [2:0]           state;
  logic [1:0]           cnt;        // field byte index
  logic                 is_wr;
  logic [31:0]          addr_sr;
  logic [31:0]          data_sr;
  logic [LGTIMEOUT-1:0] tcnt;
  logic                 cyc, stb;
  logic                 rx_en;      // holds RX off until the first clock after reset
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic [31:0]          resp_sr;    // bytes still queued behind tx_data
  logic [2:0]           resp_left;
  logic                 rx_fire, tx_fire;
  logic                 unused_bits;

  assign bus.S_RX_READY = rx_en && (state == S_IDLE || state == S_ADDR || state == S_DATA);
  assign rx_fire        = bus.S_RX_VALID && bus.S_RX_READY;
  assign tx_fire        = tx_valid && bus.M_TX_READY;

  assign bus.M_TX_VALID = tx_valid;
  assign bus.M_TX_DATA  = tx_data;
  assign bus.o_wb_cyc   = cyc;
  assign bus.o_wb_stb   = stb;
  assign bus.o_wb_we    = is_wr;
  assign bus.o_wb_addr  = addr_sr[AW+1:2];
  assign bus.o_wb_data  = data_sr;
  assign bus.o_wb_sel   = 4'hf;

  // Byte-address bits outside the word address are dropped by design.
  assign unused_bits = ^addr_sr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      addr_sr   <= '0;
      data_sr   <= '0;
      tcnt      <= '0;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      rx_en     <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      resp_sr   <= '0;
      resp_left <= '0;
    end else begin
      rx_en <= 1'b1;
      case (state)
        S_IDLE: if (rx_fire) begin
          cnt <= '0;
          if (bus.S_RX_DATA == C_RD) begin
            is_wr <= 1'b0;
            state <= S_ADDR;
          end else if (bus.S_RX_DATA == C_WR) begin
            is_wr <= 1'b1;
            state <= S_ADDR;
          end else begin
            tx_valid  <= 1'b1;
            tx_data   <= R_UNK;
            resp_left <= '0;
            state     <= S_RESP;
          end
        end
        S_ADDR: if (rx_fire) begin
          addr_sr <= {addr_sr[23:0], bus.S_RX_DATA};
          cnt     <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (is_wr) begin
              state <= S_DATA;
            end else begin
              state <= S_BUS;
              cyc   <= 1'b1;
              stb   <= 1'b1;
              tcnt  <= '0;
            end
          end
        end
        S_DATA: if (rx_fire) begin
          data_sr <= {data_sr[23:0], bus.S_RX_DATA};
          cnt     <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= S_BUS;
            cyc   <= 1'b1;
            stb   <= 1'b1;
            tcnt  <= '0;
          end
        end
        S_BUS: begin
          if (stb && !bus.i_wb_stall) stb <= 1'b0;
          // err is tested first so it wins over a simultaneous ack
          if (bus.i_wb_err || bus.i_wb_ack || tcnt == '1) begin
            cyc       <= 1'b0;
            stb       <= 1'b0;
            tx_valid  <= 1'b1;
            state     <= S_RESP;
            resp_left <= '0;
            if (bus.i_wb_err) begin
              tx_data <= R_NAK;
            end else if (bus.i_wb_ack) begin
              tx_data <= R_ACK;
              if (!is_wr) begin
                resp_sr   <= bus.i_wb_data;
                resp_left <= 3'd4;
              end
            end else begin
              tx_data <= R_NAK;   // timeout
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP: if (tx_fire) begin
          if (resp_left == '0) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tx_data   <= resp_sr[31:24];
            resp_sr   <= {resp_sr[23:0], 8'h00};
            resp_left <= resp_left - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_smi_wbbus.sv
module tb_smi_wbbus;
  localparam int AW  = 30;
  localparam int LGT = 6;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wb_op_t;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  smi_wbbus_if #(.AW(AW)) bus();
  smi_wbbus #(.AW(AW), .LGTIMEOUT(LGT)) dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));

  int n_chk = 0, n_fail = 0;
  logic [7:0] txq[$];
  wb_op_t     wbq[$];

  // slave behaviour for the next command: 0 ack, 1 err, 2 silent, 3 ack+err
  int stall_n = 0, ack_dly = 1, mode = 0, late_en = 0;
  logic [31:0] rd_word = '0;
  int cyc_rises = 0, last_cyc_len = 0, last_stb_len = 0;
  int rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Wishbone slave model; drives after the edge, checks each accepted request.
  initial begin
    bit active = 0, accepted = 0;
    int stalls = 0, dly = 0, cyc_len = 0, stb_len = 0, late = 0;
    wb_op_t e;
    bus.i_wb_stall = 0; bus.i_wb_ack = 0; bus.i_wb_err = 0; bus.i_wb_data = '0;
    forever begin
      @(posedge i_clk); #1;
      bus.i_wb_ack = 0; bus.i_wb_err = 0; bus.i_wb_stall = 0;
      bus.i_wb_data = $urandom;
      if (bus.o_wb_cyc) begin
        if (!active) begin
          active = 1; accepted = 0; stalls = stall_n;
          cyc_len = 0; stb_len = 0; cyc_rises++;
        end
        cyc_len++;
        if (bus.o_wb_stb) stb_len++;
        if (bus.o_wb_stb && !accepted) begin
          if (stalls > 0) begin
            bus.i_wb_stall = 1; stalls--;
          end else begin
            accepted = 1; dly = ack_dly;
            if (wbq.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL wb_unexpected: got addr %0h expected no request", bus.o_wb_addr);
            end else begin
              e = wbq.pop_front();
              check("wb_we", bus.o_wb_we, e.we);
              check("wb_addr", bus.o_wb_addr, e.addr);
              check("wb_sel", bus.o_wb_sel, 4'hf);
              if (e.we) check("wb_data", bus.o_wb_data, e.data);
            end
          end
        end else if (accepted && dly > 0) begin
          dly--;
          if (dly == 0) begin
            case (mode)
              0: begin bus.i_wb_ack = 1; bus.i_wb_data = rd_word; end
              1: bus.i_wb_err = 1;
              3: begin bus.i_wb_ack = 1; bus.i_wb_err = 1; end
              default: ;
            endcase
          end
        end
      end else if (active) begin
        active = 0; last_cyc_len = cyc_len; last_stb_len = stb_len;
        if (late_en != 0) late = 2;
      end else if (late > 0) begin
        late--;
        if (late == 0) begin bus.i_wb_ack = 1; bus.i_wb_data = rd_word; end
      end
    end
  end

  initial begin
    logic r = 1'b1;
    bus.M_TX_READY = 1;
    forever begin
      @(posedge i_clk); #1;
      case (rdy_mode)
        1: r = ~r;
        2: r = 1'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      bus.M_TX_READY = r;
    end
  end

  // TX scoreboard monitor
  initial begin
    logic hold = 1'b0;
    logic [7:0] hd = '0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin hold = 0; continue; end
      if (hold) begin
        check("tx_hold_valid", bus.M_TX_VALID, 1'b1);
        check("tx_hold_data", bus.M_TX_DATA, hd);
      end
      if (bus.M_TX_VALID && bus.M_TX_READY) begin
        if (txq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_unexpected: got %0h expected none", bus.M_TX_DATA);
        end else check("tx_byte", bus.M_TX_DATA, txq.pop_front());
      end
      hold = bus.M_TX_VALID && !bus.M_TX_READY;
      hd   = bus.M_TX_DATA;
    end
  end

  task automatic send_byte(logic [7:0] b);
    int n = 0;
    @(posedge i_clk); #1;
    bus.S_RX_VALID = 1; bus.S_RX_DATA = b;
    forever begin
      @(negedge i_clk);
      if (bus.S_RX_READY) break;
      if (++n > 3000) begin fail_now("rx_ready_wait"); break; end
    end
    @(posedge i_clk); #1;
    bus.S_RX_VALID = 0; bus.S_RX_DATA = 8'($urandom);
  endtask

  task automatic send_word(logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic set_slave(int m, int st, int ad);
    mode = m; stall_n = st; ack_dly = ad;
  endtask

  task automatic do_read(logic [31:0] a, logic [31:0] rw);
    wb_op_t e;
    e.we = 0; e.addr = a[AW+1:2]; e.data = '0;
    rd_word = rw;
    wbq.push_back(e);
    if (mode == 0) begin
      txq.push_back(8'h06);
      for (int i = 3; i >= 0; i--) txq.push_back(rw[i*8 +: 8]);
    end else txq.push_back(8'h15);
    send_byte(8'h52);
    send_word(a);
  endtask

  task automatic do_write(logic [31:0] a, logic [31:0] d);
    wb_op_t e;
    e.we = 1; e.addr = a[AW+1:2]; e.data = d;
    wbq.push_back(e);
    txq.push_back(mode == 0 ? 8'h06 : 8'h15);
    send_byte(8'h57);
    send_word(a);
    send_word(d);
  endtask

  task automatic wait_done(string name);
    int n = 0;
    forever begin
      @(negedge i_clk); #1;
      if (txq.size() == 0 && wbq.size() == 0 && !bus.o_wb_cyc &&
          !bus.M_TX_VALID && bus.S_RX_READY) break;
      if (++n > 4000) begin fail_now(name); break; end
    end
  endtask

  initial begin
    int r0, n;
    logic [7:0] b;
    bus.S_RX_VALID = 0; bus.S_RX_DATA = '0;

    #12;
    check("rst_rx_ready", bus.S_RX_READY, 0);
    check("rst_tx_valid", bus.M_TX_VALID, 0);
    check("rst_tx_data", bus.M_TX_DATA, 0);
    check("rst_cyc_stb_we", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we}, 0);
    check("rst_addr", bus.o_wb_addr, 0);
    check("rst_wdata", bus.o_wb_data, 0);
    @(negedge i_clk); i_reset = 0;
    repeat (2) @(negedge i_clk);
    check("post_rst_rx_ready", bus.S_RX_READY, 1);

    // directed write / read
    set_slave(0, 0, 2);
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    wait_done("write_done");
    do_read(32'h0000_0020, 32'h1234_5678);
    wait_done("read_done");

    // stall 3 then ack, TX ready toggling
    rdy_mode = 1;
    set_slave(0, 3, 2);
    do_read(32'h0000_0100, 32'hA5C3_0F96);
    wait_done("stall_done");
    check("stall_stb_len", last_stb_len, 4);
    check("stall_cyc_len", last_cyc_len, 6);
    rdy_mode = 0;

    // error, and err beating a simultaneous ack
    set_slave(1, 0, 1);
    do_read(32'h0000_0044, 32'h1111_2222);
    wait_done("err_done");
    set_slave(3, 1, 1);
    do_write(32'h0000_0048, 32'h3333_4444);
    wait_done("errack_done");

    // timeout, then a late ack that must be ignored
    set_slave(2, 0, 1); late_en = 1;
    r0 = cyc_rises;
    do_read(32'h0000_0080, 32'h5555_6666);
    wait_done("timeout_done");
    check("timeout_cyc_len", last_cyc_len, 1 << LGT);
    repeat (6) @(negedge i_clk);
    check("late_ack_no_cyc", bus.o_wb_cyc, 0);
    check("late_ack_no_tx", bus.M_TX_VALID, 0);
    check("late_ack_cyc_rises", cyc_rises, r0 + 1);
    late_en = 0;

    // unknown byte then a normal read
    set_slave(0, 0, 1);
    r0 = cyc_rises;
    txq.push_back(8'h3F);
    send_byte(8'h41);
    wait_done("unknown_done");
    check("unknown_no_cyc", cyc_rises, r0);
    do_read(32'h0000_0000, 32'h89AB_CDEF);
    wait_done("read0_done");

    // reset while the bus cycle is open
    set_slave(2, 0, 1);
    rd_word = '0;
    begin
      wb_op_t e;
      e.we = 0; e.addr = 30'h3; e.data = '0;
      wbq.push_back(e);
    end
    send_byte(8'h52);
    send_word(32'h0000_000C);
    n = 0;
    while (!bus.o_wb_cyc && n < 50) begin @(negedge i_clk); n++; end
    repeat (3) @(negedge i_clk);
    check("bus_rx_blocked", bus.S_RX_READY, 0);
    #2 i_reset = 1;
    #1;
    check("midrst_cyc_stb", {bus.o_wb_cyc, bus.o_wb_stb}, 0);
    check("midrst_tx_valid", bus.M_TX_VALID, 0);
    check("midrst_rx_ready", bus.S_RX_READY, 0);
    check("midrst_wb_taken", wbq.size(), 0);
    txq.delete();
    @(negedge i_clk); i_reset = 0;
    set_slave(0, 1, 2);
    do_read(32'h0000_0200, 32'hCAFE_F00D);
    wait_done("after_rst_done");

    // randomized commands against the protocol model
    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      int sel = $urandom_range(0, 9);
      int m   = ($urandom_range(0, 7) == 0) ? 1 : 0;
      set_slave(m, $urandom_range(0, 3), $urandom_range(1, 3));
      if (sel < 4) do_read($urandom, $urandom);
      else if (sel < 9) do_write($urandom, $urandom);
      else begin
        b = 8'($urandom);
        if (b == 8'h52 || b == 8'h57) b = 8'h00;
        txq.push_back(8'h3F);
        send_byte(b);
      end
      wait_done("rand_done");
    end

    repeat (5) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
